logic_unit_arbiter: RTL and testbench
=====================================

Name: logic_unit_arbiter

Overview:
- Shares one WIDTH-bit AND/OR logic unit (bitwise AND and OR gate arrays, purely combinational) between NREQ requesters.
- Each requester issues operand pairs plus an op select over a valid/ready handshake.
- The arbiter grants round-robin, drives the shared unit's operands and waits LU_LAT cycles for them to settle.
- It captures the selected result and returns it with the requester ID on a valid/ready response channel.

Parameters:
- NREQ, 2, number of requesters (2..8).
- WIDTH, 2, operand and result width in bits.
- LU_LAT, 1, settle cycles allowed for the shared unit (1..15).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B, same packing as req_a.
- req_op  in  NREQ  per-requester op select: 0 = AND, 1 = OR.
- lu_a  out  WIDTH  operand A to the shared unit.
- lu_b  out  WIDTH  operand B to the shared unit.
- lu_and  in  WIDTH  AND result from the shared unit.
- lu_or  in  WIDTH  OR result from the shared unit.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response accept.
- resp_id  out  clog2(NREQ), min 1  index of the requester being answered.
- resp_data  out  WIDTH  selected result.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, immediate) clears all of these to 0:
  - req_ready, resp_valid, resp_id, resp_data, lu_a, lu_b, busy.
  - Round-robin pointer, state (IDLE), settle counter, latched op and latched ID.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Pick the first asserted req_valid at or after rr_ptr, scanning upward with wrap from NREQ-1 to 0.
  - If one is found, assert req_ready for that requester only, combinationally in the same cycle. The handshake completes that cycle.
  - On the clock edge: register lu_a, lu_b, op and ID from the winner; set rr_ptr = winner+1 mod NREQ; load cnt = LU_LAT; go to EXEC.
  - With no valid request: req_ready = 0, stay in IDLE.
- EXEC:
  - req_ready = 0 for all requesters; lu_a and lu_b held stable.
  - cnt decrements each cycle.
  - When cnt == 1: capture resp_data = op ? lu_or : lu_and, assert resp_valid, go to RESP.
- RESP:
  - Hold resp_valid, resp_id and resp_data stable until resp_ready.
  - On the resp_valid && resp_ready edge: drop resp_valid, go to IDLE.
  - No new grant occurs in the same cycle as the response handshake.
- Latency:
  - Accept to resp_valid is LU_LAT+1 cycles.
  - Minimum request-to-request spacing is LU_LAT+2 cycles when resp_ready is held high.
- Requesters must hold req_a, req_b and req_op stable while req_valid is high and req_ready is low. Dropping req_valid before grant is legal and withdraws the request.
- Fairness: a continuously asserting requester is served within NREQ grants.
- Simultaneous requests: with all valid and rr_ptr = k, grant order is k, k+1, … with wrap.
- Reset mid-EXEC or mid-RESP aborts the operation; no response is emitted.
- resp_data is bitwise per bit; no arithmetic or carry.

Optional Feature:
- Macro: LU_ARB_STATS_EN.
- Defined:
  - Adds output port grant_cnt, NREQ*8 bits.
  - Holds per-requester 8-bit grant counters, incremented on each accept and saturating at 255.
  - Counters clear on rst.
- Undefined: the port and counters are absent; all other behaviour is identical.

Test Plan:
1. Single request: rst pulse; req 0 with a=2'b10, b=2'b11, op=AND.
   - req_ready[0] is high the same cycle.
   - resp_valid rises 2 cycles later (LU_LAT=1) with resp_id=0, resp_data=2'b10.
2. OR op from requester 1: a=2'b01, b=2'b10, op=1 -> resp_id=1, resp_data=2'b11.
3. Contention: both requesters valid continuously, resp_ready=1 -> grants alternate 0,1,0,1; each response spaced exactly 3 cycles apart.
4. Backpressure: hold resp_ready=0 for 5 cycles while in RESP.
   - resp_valid, resp_id and resp_data stay stable.
   - No req_ready is asserted.
   - Release -> IDLE the next cycle.
5. Reset mid-EXEC: assert rst one cycle after accept -> all outputs 0 immediately, no resp_valid afterward, next grant starts from requester 0.
6. With LU_ARB_STATS_EN: 300 grants to requester 0 and 3 to requester 1 -> grant_cnt reads 255 and 3 respectively.

Source files
------------

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin sharing of one combinational WIDTH-bit AND/OR
// unit between NREQ requesters. A grant registers the winner's operands onto
// lu_a/lu_b, waits LU_LAT settle cycles, then holds the selected result on the
// response channel until it is accepted.
// Optional build macro: LU_ARB_STATS_EN adds per-requester saturating 8-bit
// grant counters on output grant_cnt.
module logic_unit_arbiter #(
    parameter  int NREQ   = 2,
    parameter  int WIDTH  = 2,
    parameter  int LU_LAT = 1,
    localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_op,
    output logic [WIDTH-1:0]      lu_a,
    output logic [WIDTH-1:0]      lu_b,
    input  logic [WIDTH-1:0]      lu_and,
    input  logic [WIDTH-1:0]      lu_or,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic [WIDTH-1:0]      resp_data,
    output logic                  busy
`ifdef LU_ARB_STATS_EN
    ,
    output logic [NREQ*8-1:0]     grant_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [IDW:0]   NREQ_W  = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);
    localparam logic [3:0]     LAT_W   = 4'(LU_LAT);

    state_t         state, nextState;
    logic [IDW-1:0] rrPtr;
    logic [IDW-1:0] grantIdx;
    logic [IDW:0]   scanSlot;
    logic           grantFound;
    logic           grantOk;
    logic [3:0]     cnt;
    logic           curOp;

    // Round-robin scan: first valid requester at or after rrPtr, wrapping.
    always_comb begin
        grantFound = 1'b0;
        grantIdx   = '0;
        scanSlot   = '0;
        for (int off = 0; off < NREQ; off++) begin
            scanSlot = {1'b0, rrPtr} + (IDW+1)'(off);
            if (scanSlot >= NREQ_W) scanSlot = scanSlot - NREQ_W;
            if (!grantFound && req_valid[scanSlot[IDW-1:0]]) begin
                grantFound = 1'b1;
                grantIdx   = scanSlot[IDW-1:0];
            end
        end
    end

    // No grant may be offered while reset is held, even though state reads IDLE.
    assign grantOk = grantFound && !rst;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    // Next-state and same-cycle req_ready; only IDLE can grant.
    always_comb begin
        nextState = state;
        req_ready = '0;
        case (state)
            IDLE: if (grantOk) begin
                nextState           = EXEC;
                req_ready[grantIdx] = 1'b1;
            end
            EXEC: if (cnt == 4'd1) nextState = RESP;
            RESP: if (resp_ready) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Datapath: latch winner at grant, count settle cycles, capture result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rrPtr     <= '0;
            lu_a      <= '0;
            lu_b      <= '0;
            curOp     <= 1'b0;
            resp_id   <= '0;
            resp_data <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: if (grantOk) begin
                    lu_a    <= req_a[grantIdx*WIDTH +: WIDTH];
                    lu_b    <= req_b[grantIdx*WIDTH +: WIDTH];
                    curOp   <= req_op[grantIdx];
                    resp_id <= grantIdx;
                    rrPtr   <= (grantIdx == LAST_ID) ? '0 : grantIdx + 1'b1;
                    cnt     <= LAT_W;
                end
                EXEC: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == 4'd1) resp_data <= curOp ? lu_or : lu_and;
                end
                default: ;
            endcase
        end
    end

    assign resp_valid = (state == RESP);
    assign busy       = (state != IDLE);

`ifdef LU_ARB_STATS_EN
    logic [7:0] grantCnt [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : gStats
        // Per-requester grant counter, saturating at 255.
        always_ff @(posedge clk or posedge rst) begin
            if (rst)                                    grantCnt[g] <= '0;
            else if (req_ready[g] && grantCnt[g] != 8'hFF) grantCnt[g] <= grantCnt[g] + 8'd1;
        end
        assign grant_cnt[g*8 +: 8] = grantCnt[g];
    end
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench for logic_unit_arbiter (NREQ=2, WIDTH=2, LU_LAT=1).
module tb_logic_unit_arbiter;
    localparam int NREQ = 2, WIDTH = 2, LAT = 1;

    logic                  clk = 1'b0, rst = 1'b1;
    logic [NREQ-1:0]       req_valid = '0, req_ready, req_op = '0;
    logic [NREQ*WIDTH-1:0] req_a = '0, req_b = '0;
    logic [WIDTH-1:0]      lu_a, lu_b, lu_and, lu_or, resp_data;
    logic                  resp_valid, resp_ready = 1'b1, busy;
    logic [0:0]            resp_id;
`ifdef LU_ARB_STATS_EN
    logic [NREQ*8-1:0]     grant_cnt;
`endif

    int         nCmp = 0, nErr = 0;
    logic [2:0] sbQ[$];
    logic [2:0] monExp;

    logic_unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .LU_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .lu_a(lu_a), .lu_b(lu_b),
        .lu_and(lu_and), .lu_or(lu_or), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_data(resp_data), .busy(busy)
`ifdef LU_ARB_STATS_EN
        , .grant_cnt(grant_cnt)
`endif
    );

    // Shared logic unit.
    assign lu_and = lu_a & lu_b;
    assign lu_or  = lu_a | lu_b;

    always #5 clk = ~clk;

    // Response monitor: pop and compare on each response handshake.
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            nCmp++;
            if (sbQ.size() == 0) begin
                nErr++;
                $display("FAIL resp_unexpected actual id=%0d data=%b required=no response", resp_id, resp_data);
            end else begin
                monExp = sbQ.pop_front();
                if ({resp_id, resp_data} !== monExp) begin
                    nErr++;
                    $display("FAIL resp_scoreboard actual id=%0d data=%b required id=%0d data=%b",
                             resp_id, resp_data, monExp[2], monExp[1:0]);
                end
            end
        end
    end

    task automatic send_req(input int id, input logic [1:0] a, input logic [1:0] b, input logic op);
        bit got = 1'b0;
        @(posedge clk); #1;
        req_a[id*WIDTH +: WIDTH] = a;
        req_b[id*WIDTH +: WIDTH] = b;
        req_op[id]    = op;
        req_valid[id] = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if (req_ready[id]) begin
                got = 1'b1;
                sbQ.push_back({id[0], op ? (a | b) : (a & b)});
            end else begin
                @(posedge clk); #1;
            end
        end
        nCmp++;
        if (!got) begin nErr++; $display("FAIL send_req_grant id=%0d actual=not granted required=granted", id); end
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (sbQ.size() != 0 && w < 30) begin @(posedge clk); w++; end
        @(posedge clk); @(posedge clk); #1;
        nCmp++;
        if (sbQ.size() != 0) begin nErr++; $display("FAIL drain actual=%0d pending required=0", sbQ.size()); end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 2'b11; resp_ready = 1'b1;
        @(posedge clk); #1;
        nCmp++; if (req_ready !== 2'b00) begin nErr++; $display("FAIL reset_req_ready actual=%b required=00", req_ready); end
        nCmp++; if ({resp_valid, busy} !== 2'b00) begin nErr++; $display("FAIL reset_valid_busy actual=%b required=00", {resp_valid, busy}); end
        nCmp++; if ({resp_id, resp_data, lu_a, lu_b} !== 7'd0) begin nErr++; $display("FAIL reset_data actual=%b required=0", {resp_id, resp_data, lu_a, lu_b}); end
        @(posedge clk); #1;
        req_valid = '0; rst = 1'b0;
    endtask

    task automatic test_single_and();
        @(posedge clk); #1;
        req_a[1:0] = 2'b10; req_b[1:0] = 2'b11; req_op[0] = 1'b0; req_valid = 2'b01;
        #1;
        nCmp++; if (req_ready !== 2'b01) begin nErr++; $display("FAIL single_ready actual=%b required=01", req_ready); end
        sbQ.push_back({1'b0, 2'b10});
        @(posedge clk); #1; req_valid = '0; #1;
        nCmp++; if ({busy, resp_valid, lu_a, lu_b} !== 6'b10_1011) begin nErr++; $display("FAIL single_exec actual=%b required=101011", {busy, resp_valid, lu_a, lu_b}); end
        @(posedge clk); #2;
        nCmp++; if ({resp_valid, resp_id, resp_data} !== 4'b1_0_10) begin nErr++; $display("FAIL single_latency actual=%b required=1010", {resp_valid, resp_id, resp_data}); end
        @(posedge clk); #2;
        nCmp++; if ({resp_valid, busy} !== 2'b00) begin nErr++; $display("FAIL single_idle actual=%b required=00", {resp_valid, busy}); end
    endtask

    task automatic test_or();
        @(posedge clk); #1;
        req_a[3:2] = 2'b01; req_b[3:2] = 2'b10; req_op[1] = 1'b1; req_valid = 2'b10;
        #1;
        nCmp++; if (req_ready !== 2'b10) begin nErr++; $display("FAIL or_ready actual=%b required=10", req_ready); end
        sbQ.push_back({1'b1, 2'b11});
        @(posedge clk); #1; req_valid = '0;
        @(posedge clk); #2;
        nCmp++; if ({resp_valid, resp_id, resp_data} !== 4'b1_1_11) begin nErr++; $display("FAIL or_resp actual=%b required=1111", {resp_valid, resp_id, resp_data}); end
        drain();
    endtask

    task automatic test_contention();
        logic [1:0] expOh = 2'b01;
        int resps = 0, lastResp = -1;
        @(posedge clk); #1;
        req_a = 4'b10_11; req_b = 4'b00_01; req_op = 2'b10; req_valid = 2'b11;
        for (int cyc = 0; cyc < 40 && resps < 4; cyc++) begin
            #1;
            if (req_ready != 2'b00) begin
                nCmp++;
                if (req_ready !== expOh) begin nErr++; $display("FAIL contention_order actual=%b required=%b", req_ready, expOh); end
                sbQ.push_back({expOh[1], expOh[1] ? 2'b10 : 2'b01});
                expOh = {expOh[0], expOh[1]};
            end
            if (resp_valid) begin
                resps++;
                if (lastResp >= 0) begin
                    nCmp++;
                    if (cyc - lastResp != 3) begin nErr++; $display("FAIL contention_spacing actual=%0d required=3", cyc - lastResp); end
                end
                lastResp = cyc;
            end
            @(posedge clk); #1;
        end
        req_valid = '0;
        nCmp++; if (resps != 4) begin nErr++; $display("FAIL contention_count actual=%0d required=4", resps); end
        drain();
    endtask

    task automatic test_backpressure();
        int w = 0;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        req_a[1:0] = 2'b01; req_b[1:0] = 2'b11; req_op[0] = 1'b1; req_valid = 2'b01;
        #1;
        nCmp++; if (req_ready !== 2'b01) begin nErr++; $display("FAIL bp_ready actual=%b required=01", req_ready); end
        sbQ.push_back({1'b0, 2'b11});
        @(posedge clk); #1;
        req_a[3:2] = 2'b11; req_b[3:2] = 2'b10; req_op[1] = 1'b0; req_valid = 2'b10;
        #1;
        while (!resp_valid && w < 10) begin @(posedge clk); #2; w++; end
        nCmp++; if (!resp_valid) begin nErr++; $display("FAIL bp_timeout actual=0 required=1"); end
        for (int i = 0; i < 5; i++) begin
            nCmp++;
            if ({resp_valid, resp_id, resp_data, req_ready} !== 6'b1_0_11_00) begin
                nErr++; $display("FAIL bp_hold cyc=%0d actual=%b required=101100", i, {resp_valid, resp_id, resp_data, req_ready});
            end
            @(posedge clk); #2;
        end
        resp_ready = 1'b1;
        @(posedge clk); #2;
        nCmp++; if ({resp_valid, busy, req_ready} !== 4'b00_10) begin nErr++; $display("FAIL bp_release actual=%b required=0010", {resp_valid, busy, req_ready}); end
        sbQ.push_back({1'b1, 2'b10});
        @(posedge clk); #1; req_valid = '0;
        drain();
    endtask

    task automatic test_reset_mid_exec();
        @(posedge clk); #1;
        req_a[1:0] = 2'b11; req_b[1:0] = 2'b11; req_op[0] = 1'b0; req_valid = 2'b01;
        #1;
        nCmp++; if (req_ready !== 2'b01) begin nErr++; $display("FAIL rst_pre_ready actual=%b required=01", req_ready); end
        sbQ.push_back({1'b0, 2'b11});
        @(posedge clk); #1;
        rst = 1'b1; req_valid = '0;
        #1;
        nCmp++; if ({busy, resp_valid, req_ready, resp_id, resp_data, lu_a, lu_b} !== 11'd0) begin
            nErr++; $display("FAIL rst_mid_exec actual=%b required=0", {busy, resp_valid, req_ready, resp_id, resp_data, lu_a, lu_b});
        end
        sbQ.delete();
        @(posedge clk); @(posedge clk); #1; rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            nCmp++; if (resp_valid !== 1'b0) begin nErr++; $display("FAIL rst_no_resp cyc=%0d actual=%b required=0", i, resp_valid); end
            @(posedge clk); #1;
        end
        req_a = 4'b00_01; req_b = 4'b00_01; req_op = 2'b00; req_valid = 2'b11;
        #1;
        nCmp++; if (req_ready !== 2'b01) begin nErr++; $display("FAIL rst_rr_restart actual=%b required=01", req_ready); end
        sbQ.push_back({1'b0, 2'b01});
        @(posedge clk); #1; req_valid = '0;
        drain();
    endtask

`ifdef LU_ARB_STATS_EN
    task automatic test_stats();
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        nCmp++; if (grant_cnt !== 16'd0) begin nErr++; $display("FAIL stats_reset actual=%h required=0000", grant_cnt); end
        for (int i = 0; i < 300; i++) send_req(0, 2'(i), 2'b11, 1'b0);
        for (int i = 0; i < 3; i++)   send_req(1, 2'b01, 2'(i), 1'b1);
        drain();
        nCmp++; if (grant_cnt[7:0] !== 8'd255) begin nErr++; $display("FAIL stats_req0 actual=%0d required=255", grant_cnt[7:0]); end
        nCmp++; if (grant_cnt[15:8] !== 8'd3) begin nErr++; $display("FAIL stats_req1 actual=%0d required=3", grant_cnt[15:8]); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_and();
        test_or();
        test_contention();
        test_backpressure();
        test_reset_mid_exec();
        send_req(1, 2'b10, 2'b01, 1'b1);
        send_req(0, 2'b01, 2'b01, 1'b0);
        drain();
`ifdef LU_ARB_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule
